// File: rtl/up3_pkg.sv
// Shared state encodings, opcode constants and strobe bundle for the up3 controller and datapath.
// Pure declarations: no latency, no backpressure.
package up3_pkg;

    typedef enum logic [2:0] {
        S_F1   = 3'd0,
        S_F2   = 3'd1,
        S_F3   = 3'd2,
        S_F4   = 3'd3,
        S_DEC  = 3'd4,
        S_EXW  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_AND   = 8'h05;
    localparam logic [7:0] OP_LOADI = 8'h06;
    localparam logic [7:0] OP_JUMP  = 8'h07;
    localparam logic [7:0] OP_JNEG  = 8'h08;
    localparam logic [7:0] OP_JZERO = 8'h09;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_MEMRD,
        CLS_STORE,
        CLS_LOADI,
        CLS_JUMP,
        CLS_JNEG,
        CLS_JZERO,
        CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic load_pc;
        logic incr_pc;
        logic load_iru;
        logic load_irl;
        logic load_ac;
        logic store_mem;
        logic fetch;
    } strobes_t;

endpackage

// File: rtl/up3_if.sv
// Controller-to-datapath bundle: opcode/flags in, datapath strobes out.
// Purely combinational wiring; no latency, no backpressure.
interface up3_if;
    logic [7:0] opcode;
    logic       nflg;
    logic       zflg;
    logic       LOAD_PC;
    logic       INCR_PC;
    logic       LOAD_IRU;
    logic       LOAD_IRL;
    logic       LOAD_AC;
    logic       STORE_MEM;
    logic       fetch;

    modport master (
        input  opcode, nflg, zflg,
        output LOAD_PC, INCR_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, fetch
    );

    modport slave (
        output opcode, nflg, zflg,
        input  LOAD_PC, INCR_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, fetch
    );
endinterface

// File: rtl/up3_decode.sv
// Opcode classifier: maps the IR upper byte to the action class used in DEC.
// Combinational, zero latency; no backpressure.
module up3_decode
    import up3_pkg::*;
(
    input  logic [7:0] opcode,
    output op_class_t  cls
);

    always_comb begin
        cls = CLS_NOP;
        case (opcode)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND: cls = CLS_MEMRD;
            OP_STORE:                        cls = CLS_STORE;
            OP_LOADI:                        cls = CLS_LOADI;
            OP_JUMP:                         cls = CLS_JUMP;
            OP_JNEG:                         cls = CLS_JNEG;
            OP_JZERO:                        cls = CLS_JZERO;
            OP_HALT:                         cls = CLS_HALT;
            default:                         cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/up3_control.sv
// up3 sequencer: two-byte fetch, decode, optional execute-writeback; retire counter and halt flag.
// 5 cycles per instruction (6 for memory operands); no backpressure, strobes forced low while reset is high.
module up3_control
    import up3_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    up3_if.master            dp,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_t           cur_state;
    state_t           nxt_state;
    op_class_t        cls;
    strobes_t         stb;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    up3_decode u_decode (
        .opcode (dp.opcode),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_F1;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = S_F1;
        stb       = '0;
        retire    = 1'b0;
        case (cur_state)
            S_F1: begin
                stb.fetch = 1'b1;
                nxt_state = S_F2;
            end
            S_F2: begin
                stb.fetch    = 1'b1;
                stb.load_iru = 1'b1;
                stb.incr_pc  = 1'b1;
                nxt_state    = S_F3;
            end
            S_F3: begin
                stb.fetch = 1'b1;
                nxt_state = S_F4;
            end
            S_F4: begin
                stb.fetch    = 1'b1;
                stb.load_irl = 1'b1;
                stb.incr_pc  = 1'b1;
                nxt_state    = S_DEC;
            end
            S_DEC: begin
                // Every DEC exit except the memory-operand path retires here.
                retire = 1'b1;
                case (cls)
                    CLS_MEMRD: begin
                        retire    = 1'b0;
                        nxt_state = S_EXW;
                    end
                    CLS_STORE: stb.store_mem = 1'b1;
                    CLS_LOADI: stb.load_ac   = 1'b1;
                    CLS_JUMP:  stb.load_pc   = 1'b1;
                    CLS_JNEG:  stb.load_pc   = dp.nflg;
                    CLS_JZERO: stb.load_pc   = dp.zflg;
                    CLS_HALT:  nxt_state     = S_HALT;
                    default:   nxt_state     = S_F1;
                endcase
            end
            S_EXW: begin
                stb.load_ac = 1'b1;
                retire      = 1'b1;
                nxt_state   = S_F1;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                nxt_state = S_F1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (retire && (cnt != '1)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign dp.LOAD_PC   = stb.load_pc   & ~reset;
    assign dp.INCR_PC   = stb.incr_pc   & ~reset;
    assign dp.LOAD_IRU  = stb.load_iru  & ~reset;
    assign dp.LOAD_IRL  = stb.load_irl  & ~reset;
    assign dp.LOAD_AC   = stb.load_ac   & ~reset;
    assign dp.STORE_MEM = stb.store_mem & ~reset;
    assign dp.fetch     = stb.fetch     & ~reset;

    assign halted      = (cur_state == S_HALT) && !reset;
    assign state       = cur_state;
    assign instr_count = reset ? '0 : cnt;

endmodule
